pc_trap_unit: RTL and testbench
===============================

# pc_trap_unit

Parametrised program-counter unit for the multi-cycle core: holds the fetch PC and the PC of the instruction in flight, and redirects to a fixed trap vector on exceptions. A small LIFO of exception PCs supports nested traps and `mret` returns. It sits between the control FSM / next-PC mux and the instruction-memory address port, and replaces the plain PC register.

## Interface
Parameters:
- XLEN, 32: PC width in bits.
- RESET_VECTOR, 0: PC value after reset.
- TRAP_VECTOR, 32'h0000_0100: handler address loaded on any trap.
- EPC_DEPTH, 4: exception-PC stack entries, legal range 1..16.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_arst  in  1  reset, asynchronous and active-high.
- i_nextPc  in  XLEN  candidate next PC from the next-PC mux.
- i_pcWriteEn  in  1  load i_nextPc.
- i_oldPcCapture  in  1  copy the current o_pc into o_oldPc (fetch state).
- i_trap  in  1  exception or interrupt request from the control FSM.
- i_mret  in  1  return from the handler.
- o_pc  out  XLEN  current PC (registered).
- o_oldPc  out  XLEN  PC of the instruction in flight (registered).
- o_pcPlus4  out  XLEN  o_pc + 4, combinational, wraps modulo 2^XLEN.
- o_epcTop  out  XLEN  top of the EPC stack; 0 when the stack is empty.
- o_epcDepth  out  $clog2(EPC_DEPTH+1)  number of valid entries.
- o_epcFull / o_epcEmpty  out  1  stack status.
- o_stackErr  out  1  sticky flag for overflow or underflow; cleared only by reset.
- o_misaligned  out  1  one-cycle registered pulse for a misaligned-target trap.

## Operation
- Action priority per cycle: TRAP > RET > LOAD > HOLD.
- TRAP (i_trap, or a misaligned LOAD when the check is enabled):
  - Push the pre-edge o_oldPc onto the stack.
  - o_pc <= TRAP_VECTOR.
  - If the stack is full: no push, contents unchanged, o_stackErr set, redirect still happens.
- RET (i_mret and not TRAP):
  - If the stack is non-empty: o_pc <= top, pop.
  - If empty: o_pc unchanged, o_stackErr set.
- LOAD (i_pcWriteEn only): o_pc <= i_nextPc.
- HOLD: all state unchanged.
- i_oldPcCapture is independent of the action: o_oldPc <= pre-edge o_pc, even in the same cycle as a LOAD, TRAP or RET.
- Simultaneous i_trap and i_mret: the trap wins and mret is dropped, so the stack sees only the push.
- Stack: push and pop never occur in the same cycle. Depth saturates at EPC_DEPTH and 0.

## Timing
- Every state change occurs on the rising edge with 1-cycle latency. A new o_pc is visible the cycle after the request.
- o_pcPlus4 and o_epcTop are combinational from registers. There are no combinational paths from inputs to outputs.
- Reset values:
  - o_pc = RESET_VECTOR, o_oldPc = RESET_VECTOR.
  - o_epcDepth = 0, o_epcEmpty = 1, o_epcFull = 0.
  - o_stackErr = 0, o_misaligned = 0, o_epcTop = 0.
- Reset asserted mid-operation clears the stack and all flags immediately (asynchronously). The first action after deassertion is taken at the next rising edge.
- o_misaligned is high for exactly the one cycle following the edge that took the misaligned trap.

## Configuration
- PC_MISALIGN_CHECK_EN defined:
  - A LOAD with i_nextPc[1:0] != 0 is converted to TRAP (push, redirect to TRAP_VECTOR).
  - o_misaligned pulses.
- Macro undefined:
  - i_nextPc is loaded verbatim.
  - o_misaligned is tied to 0.
  - No alignment logic is synthesised.

## Structure
- Package pc_pkg holds:
  - pc_action_t enum: PC_HOLD, PC_LOAD, PC_TRAP, PC_RET.
  - Default RESET_VECTOR and TRAP_VECTOR constants.
  - Instruction width constant INSTR_BYTES = 4.
- Sub-module epc_stack:
  - Parametrised LIFO (XLEN, EPC_DEPTH) with push, pop, top, depth, full, empty and overflow/underflow strobes.
  - The top level holds the priority decode, the PC and oldPc registers, and the sticky flags.

## Test plan
- Reset, then 3 LOADs of 0x4, 0x8, 0xC: o_pc follows with 1-cycle lag; o_pcPlus4 = 0x10 at the end; o_stackErr = 0.
- o_oldPc = 0x40, then i_trap: next cycle o_pc = 0x100, o_epcTop = 0x40, o_epcDepth = 1. Then i_mret: o_pc = 0x40, o_epcEmpty = 1.
- EPC_DEPTH = 4, five traps with o_oldPc = 0x10..0x50: depth = 4, o_epcTop = 0x40, o_stackErr = 1. Four mrets return 0x40, 0x30, 0x20, 0x10 in order.
- i_trap, i_mret and i_pcWriteEn all high (nextPc = 0x200): o_pc = 0x100, depth increments by 1, no pop.
- mret on an empty stack with o_pc = 0x80: o_pc stays 0x80, o_stackErr = 1.
- With PC_MISALIGN_CHECK_EN, LOAD of 0x202: o_pc = 0x100, o_misaligned high for one cycle, depth = 1. Without the macro: o_pc = 0x202.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter / trap unit.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_LOAD = 2'd1,
        PC_TRAP = 2'd2,
        PC_RET  = 2'd3
    } pc_action_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int unsigned INSTR_BYTES          = 4;

endpackage

// File: rtl/epc_stack.sv
// LIFO of exception PCs; push wins if both strobes are ever raised together,
// and push-on-full / pop-on-empty leave the contents alone and raise a strobe.
module epc_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned EPC_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic [XLEN-1:0]                  din,
    output logic [XLEN-1:0]                  top,
    output logic [$clog2(EPC_DEPTH+1)-1:0]   depth,
    output logic                             full,
    output logic                             empty,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int unsigned DW = $clog2(EPC_DEPTH + 1);

    logic [XLEN-1:0] mem [EPC_DEPTH];

    assign full      = (depth == DW'(EPC_DEPTH));
    assign empty     = (depth == '0);
    assign overflow  = push && full;
    assign underflow = pop && !push && empty;

    // Top-of-stack read as a compare mux to avoid an over-wide array index.
    always_comb begin
        top = '0;
        for (int i = 0; i < int'(EPC_DEPTH); i++) begin
            if (depth == DW'(i + 1)) top = mem[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth <= '0;
            for (int i = 0; i < int'(EPC_DEPTH); i++) mem[i] <= '0;
        end else if (push) begin
            if (!full) begin
                for (int i = 0; i < int'(EPC_DEPTH); i++) begin
                    if (depth == DW'(i)) mem[i] <= din;
                end
                depth <= depth + DW'(1);
            end
        end else if (pop && !empty) begin
            depth <= depth - DW'(1);
        end
    end

endmodule

// File: rtl/pc_trap_unit.sv
// Fetch PC, in-flight PC and trap/return redirection with a nested EPC stack.
// Optional misaligned-target trapping is enabled by defining PC_MISALIGN_CHECK_EN.
module pc_trap_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned     EPC_DEPTH    = 4
) (
    input  logic                           i_clk,
    input  logic                           i_arst,
    input  logic [XLEN-1:0]                i_nextPc,
    input  logic                           i_pcWriteEn,
    input  logic                           i_oldPcCapture,
    input  logic                           i_trap,
    input  logic                           i_mret,
    output logic [XLEN-1:0]                o_pc,
    output logic [XLEN-1:0]                o_oldPc,
    output logic [XLEN-1:0]                o_pcPlus4,
    output logic [XLEN-1:0]                o_epcTop,
    output logic [$clog2(EPC_DEPTH+1)-1:0] o_epcDepth,
    output logic                           o_epcFull,
    output logic                           o_epcEmpty,
    output logic                           o_stackErr,
    output logic                           o_misaligned
);

    pc_action_t action;
    logic       load_trap;
    logic       push;
    logic       pop;
    logic       overflow;
    logic       underflow;

`ifdef PC_MISALIGN_CHECK_EN
    // A load only happens when nothing of higher priority is requested.
    assign load_trap = i_pcWriteEn && !i_trap && !i_mret && (i_nextPc[1:0] != 2'b00);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) o_misaligned <= 1'b0;
        else        o_misaligned <= load_trap;
    end
`else
    assign load_trap    = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    // Priority decode: TRAP > RET > LOAD > HOLD.
    always_comb begin
        action = PC_HOLD;
        if (i_trap || load_trap) action = PC_TRAP;
        else if (i_mret)         action = PC_RET;
        else if (i_pcWriteEn)    action = PC_LOAD;
    end

    assign push      = (action == PC_TRAP);
    assign pop       = (action == PC_RET);
    assign o_pcPlus4 = o_pc + XLEN'(INSTR_BYTES);

    epc_stack #(
        .XLEN      (XLEN),
        .EPC_DEPTH (EPC_DEPTH)
    ) u_epc_stack (
        .clk       (i_clk),
        .rst       (i_arst),
        .push      (push),
        .pop       (pop),
        .din       (o_oldPc),
        .top       (o_epcTop),
        .depth     (o_epcDepth),
        .full      (o_epcFull),
        .empty     (o_epcEmpty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_pc       <= RESET_VECTOR;
            o_oldPc    <= RESET_VECTOR;
            o_stackErr <= 1'b0;
        end else begin
            case (action)
                PC_TRAP: o_pc <= TRAP_VECTOR;
                PC_RET:  if (!o_epcEmpty) o_pc <= o_epcTop;
                PC_LOAD: o_pc <= i_nextPc;
                default: o_pc <= o_pc;
            endcase
            if (i_oldPcCapture)         o_oldPc    <= o_pc;
            if (overflow || underflow)  o_stackErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_trap_unit.sv
// Directed self-checking bench for pc_trap_unit (default XLEN/vectors, EPC_DEPTH = 4).
module tb_pc_trap_unit;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        we;
    logic        cap;
    logic        trap;
    logic        mret;
    logic [31:0] pc;
    logic [31:0] old_pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc_top;
    logic [2:0]  epc_depth;
    logic        epc_full;
    logic        epc_empty;
    logic        stack_err;
    logic        misaligned;

    int n_pass  = 0;
    int n_total = 0;

    pc_trap_unit dut (
        .i_clk          (clk),
        .i_arst         (rst),
        .i_nextPc       (next_pc),
        .i_pcWriteEn    (we),
        .i_oldPcCapture (cap),
        .i_trap         (trap),
        .i_mret         (mret),
        .o_pc           (pc),
        .o_oldPc        (old_pc),
        .o_pcPlus4      (pc_plus4),
        .o_epcTop       (epc_top),
        .o_epcDepth     (epc_depth),
        .o_epcFull      (epc_full),
        .o_epcEmpty     (epc_empty),
        .o_stackErr     (stack_err),
        .o_misaligned   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs; outputs are stable 1 time unit after the edge.
    task automatic drive(input logic w, input logic [31:0] np, input logic c,
                         input logic t, input logic m);
        we = w; next_pc = np; cap = c; trap = t; mret = m;
        @(posedge clk); #1;
        we = 1'b0; cap = 1'b0; trap = 1'b0; mret = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        we = 1'b0; cap = 1'b0; trap = 1'b0; mret = 1'b0; next_pc = '0;
        do_reset();
        n_total++; if (pc !== 32'h0) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); else n_pass++;
        n_total++; if (old_pc !== 32'h0) $display("FAIL reset_oldpc got=%h exp=%h", old_pc, 32'h0); else n_pass++;
        n_total++; if (epc_depth !== 3'd0) $display("FAIL reset_depth got=%0d exp=0", epc_depth); else n_pass++;
        n_total++; if (epc_empty !== 1'b1 || epc_full !== 1'b0)
            $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", epc_empty, epc_full); else n_pass++;
        n_total++; if (stack_err !== 1'b0 || misaligned !== 1'b0)
            $display("FAIL reset_err got err=%b mis=%b exp 0 0", stack_err, misaligned); else n_pass++;
        n_total++; if (epc_top !== 32'h0) $display("FAIL reset_top got=%h exp=%h", epc_top, 32'h0); else n_pass++;
        n_total++; if (pc_plus4 !== 32'h4) $display("FAIL reset_plus4 got=%h exp=%h", pc_plus4, 32'h4); else n_pass++;
    endtask

    task automatic test_load();
        logic [31:0] vals [3];
        vals[0] = 32'h4; vals[1] = 32'h8; vals[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; next_pc = vals[i];
            #1;
            n_total++; if (pc_plus4 !== pc + 32'h4 || pc === vals[i])
                $display("FAIL load_lag%0d got=%h before edge exp old value", i, pc); else n_pass++;
            drive(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
            n_total++; if (pc !== vals[i]) $display("FAIL load%0d got=%h exp=%h", i, pc, vals[i]); else n_pass++;
        end
        n_total++; if (pc_plus4 !== 32'h10) $display("FAIL load_plus4 got=%h exp=%h", pc_plus4, 32'h10); else n_pass++;
        n_total++; if (stack_err !== 1'b0) $display("FAIL load_err got=%b exp=0", stack_err); else n_pass++;
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        n_total++; if (pc_plus4 !== 32'h0) $display("FAIL plus4_wrap got=%h exp=%h", pc_plus4, 32'h0); else n_pass++;
    endtask

    task automatic test_trap_ret();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        n_total++; if (old_pc !== 32'h40) $display("FAIL capture got=%h exp=%h", old_pc, 32'h40); else n_pass++;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_total++; if (pc !== 32'h100) $display("FAIL trap_pc got=%h exp=%h", pc, 32'h100); else n_pass++;
        n_total++; if (epc_top !== 32'h40) $display("FAIL trap_top got=%h exp=%h", epc_top, 32'h40); else n_pass++;
        n_total++; if (epc_depth !== 3'd1) $display("FAIL trap_depth got=%0d exp=1", epc_depth); else n_pass++;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_total++; if (pc !== 32'h100 || epc_depth !== 3'd1)
            $display("FAIL hold got pc=%h depth=%0d exp pc=100 depth=1", pc, epc_depth); else n_pass++;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        n_total++; if (pc !== 32'h40) $display("FAIL mret_pc got=%h exp=%h", pc, 32'h40); else n_pass++;
        n_total++; if (epc_empty !== 1'b1 || epc_top !== 32'h0)
            $display("FAIL mret_empty got empty=%b top=%h exp empty=1 top=0", epc_empty, epc_top); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] exp_ret [4];
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'(i * 16), 1'b0, 1'b0, 1'b0);
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            if (i == 4) begin
                n_total++; if (epc_full !== 1'b1 || stack_err !== 1'b0)
                    $display("FAIL fill4 got full=%b err=%b exp full=1 err=0", epc_full, stack_err); else n_pass++;
            end
        end
        n_total++; if (epc_depth !== 3'd4) $display("FAIL ovf_depth got=%0d exp=4", epc_depth); else n_pass++;
        n_total++; if (epc_top !== 32'h40) $display("FAIL ovf_top got=%h exp=%h", epc_top, 32'h40); else n_pass++;
        n_total++; if (stack_err !== 1'b1) $display("FAIL ovf_err got=%b exp=1", stack_err); else n_pass++;
        n_total++; if (pc !== 32'h100) $display("FAIL ovf_redirect got=%h exp=%h", pc, 32'h100); else n_pass++;
        exp_ret[0] = 32'h40; exp_ret[1] = 32'h30; exp_ret[2] = 32'h20; exp_ret[3] = 32'h10;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            n_total++; if (pc !== exp_ret[i]) $display("FAIL ret%0d got=%h exp=%h", i, pc, exp_ret[i]); else n_pass++;
        end
        n_total++; if (epc_empty !== 1'b1 || stack_err !== 1'b1)
            $display("FAIL ret_done got empty=%b err=%b exp 1 1", epc_empty, stack_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h60, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
        n_total++; if (pc !== 32'h100) $display("FAIL all_high_pc got=%h exp=%h", pc, 32'h100); else n_pass++;
        n_total++; if (epc_depth !== 3'd1 || epc_top !== 32'h60)
            $display("FAIL all_high_stack got depth=%0d top=%h exp depth=1 top=60", epc_depth, epc_top); else n_pass++;
        n_total++; if (old_pc !== 32'h60) $display("FAIL all_high_oldpc got=%h exp=%h", old_pc, 32'h60); else n_pass++;
    endtask

    task automatic test_empty_mret();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++; if (epc_depth !== 3'd0 || stack_err !== 1'b0 || pc !== 32'h0)
            $display("FAIL async_rst got depth=%0d err=%b pc=%h exp 0 0 0", epc_depth, stack_err, pc); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        n_total++; if (pc !== 32'h80) $display("FAIL empty_mret_pc got=%h exp=%h", pc, 32'h80); else n_pass++;
        n_total++; if (stack_err !== 1'b1 || epc_depth !== 3'd0)
            $display("FAIL empty_mret_err got err=%b depth=%0d exp err=1 depth=0", stack_err, epc_depth); else n_pass++;
    endtask

    task automatic test_misalign();
        do_reset();
        drive(1'b1, 32'h202, 1'b0, 1'b0, 1'b0);
`ifdef PC_MISALIGN_CHECK_EN
        n_total++; if (pc !== 32'h100) $display("FAIL mis_pc got=%h exp=%h", pc, 32'h100); else n_pass++;
        n_total++; if (misaligned !== 1'b1) $display("FAIL mis_pulse got=%b exp=1", misaligned); else n_pass++;
        n_total++; if (epc_depth !== 3'd1) $display("FAIL mis_depth got=%0d exp=1", epc_depth); else n_pass++;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_total++; if (misaligned !== 1'b0) $display("FAIL mis_once got=%b exp=0", misaligned); else n_pass++;
`else
        n_total++; if (pc !== 32'h202) $display("FAIL mis_pc got=%h exp=%h", pc, 32'h202); else n_pass++;
        n_total++; if (misaligned !== 1'b0) $display("FAIL mis_pulse got=%b exp=0", misaligned); else n_pass++;
        n_total++; if (epc_depth !== 3'd0) $display("FAIL mis_depth got=%0d exp=0", epc_depth); else n_pass++;
`endif
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_load();
        test_trap_ret();
        test_overflow();
        test_back_to_back();
        test_empty_mret();
        test_misalign();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
